spike_emitter: RTL and testbench

SPIKE_EMITTER -- requirements
Module: spike_emitter

---
 rtl/spike_emitter.sv | 155 +++++++++++++++
 tb/tb_spike_emitter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_emitter.sv
// rtl/spike_emitter.sv - emits one spike event per sorted pixel index; optional inter-event gap via SPIKE_EMITTER_GAP_EN
module spike_emitter #(
    parameter int IMAGE_SIZE      = 5,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int INDEX_BITS      = 4,
    parameter int MAX_SPIKES      = IMAGE_SIZE,
    parameter int GAP_CYCLES      = 2
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [INDEX_BITS-1:0]      sorted_indexes [0:IMAGE_SIZE-1],
    input  logic                       sort_done,
    input  logic                       abort,
    input  logic                       event_ready,
    output logic                       event_valid,
    output logic [INDEX_BITS-1:0]      event_addr,
    output logic [IMAGE_SIZE_BITS:0]   event_rank,
    output logic                       event_last,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       frame_overrun
);

    localparam int RW = IMAGE_SIZE_BITS + 1;

    if (MAX_SPIKES < 1 || MAX_SPIKES > IMAGE_SIZE || GAP_CYCLES < 0) begin : g_param_check
        $error("spike_emitter: illegal parameter combination");
    end

`ifdef SPIKE_EMITTER_GAP_EN
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    typedef enum logic [1:0] {IDLE, EMIT, GAP, FINISH} state_t;
    logic [GW-1:0] r_gap_cnt;
    logic [GW-1:0] w_gap_nxt;
`else
    typedef enum logic [1:0] {IDLE, EMIT, FINISH} state_t;
`endif

    state_t                r_state;
    state_t                w_state_nxt;
    logic [RW-1:0]         r_rank;
    logic [RW-1:0]         w_rank_nxt;
    logic [INDEX_BITS-1:0] r_buf [0:IMAGE_SIZE-1];
    logic                  r_overrun;
    logic                  w_overrun_nxt;
    logic                  w_capture;
    logic                  w_emit;
    logic                  w_last;
    logic [INDEX_BITS-1:0] w_addr;

    assign w_emit = (r_state == EMIT);
    assign w_last = (r_rank == RW'(MAX_SPIKES - 1));

    always_comb begin
        w_addr = '0;
        for (int i = 0; i < IMAGE_SIZE; i++) begin
            if (r_rank == RW'(i)) begin
                w_addr = r_buf[i];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rank_nxt    = r_rank;
        w_overrun_nxt = r_overrun;
        w_capture     = 1'b0;
`ifdef SPIKE_EMITTER_GAP_EN
        w_gap_nxt     = r_gap_cnt;
`endif
        if (sort_done && r_state != IDLE) begin
            w_overrun_nxt = 1'b1;
        end
        case (r_state)
            IDLE: begin
                // abort outranks a simultaneous sort_done: no capture, overrun untouched
                if (sort_done && !abort) begin
                    w_capture     = 1'b1;
                    w_rank_nxt    = '0;
                    w_overrun_nxt = 1'b0;
                    w_state_nxt   = EMIT;
                end
            end
            EMIT: begin
                if (event_ready) begin
                    if (w_last) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_rank_nxt = r_rank + RW'(1);
`ifdef SPIKE_EMITTER_GAP_EN
                        if (GAP_CYCLES > 0) begin
                            w_state_nxt = GAP;
                            w_gap_nxt   = GW'(GAP_CYCLES);
                        end
`endif
                    end
                end
            end
`ifdef SPIKE_EMITTER_GAP_EN
            GAP: begin
                w_gap_nxt = r_gap_cnt - GW'(1);
                if (r_gap_cnt <= GW'(1)) begin
                    w_state_nxt = EMIT;
                end
            end
`endif
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (abort && r_state != IDLE) begin
            w_state_nxt = IDLE;
            w_rank_nxt  = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            r_rank    <= '0;
            r_overrun <= 1'b0;
`ifdef SPIKE_EMITTER_GAP_EN
            r_gap_cnt <= '0;
`endif
            for (int i = 0; i < IMAGE_SIZE; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_rank    <= w_rank_nxt;
            r_overrun <= w_overrun_nxt;
`ifdef SPIKE_EMITTER_GAP_EN
            r_gap_cnt <= w_gap_nxt;
`endif
            if (w_capture) begin
                for (int i = 0; i < IMAGE_SIZE; i++) begin
                    r_buf[i] <= sorted_indexes[i];
                end
            end
        end
    end

    // event fields are forced to zero outside EMIT so reset and idle look identical
    assign event_valid   = w_emit;
    assign event_addr    = w_emit ? w_addr : '0;
    assign event_rank    = w_emit ? r_rank : '0;
    assign event_last    = w_emit & w_last;
    assign busy          = (r_state != IDLE);
    assign frame_done    = (r_state == FINISH);
    assign frame_overrun = r_overrun;

endmodule

// File: tb/tb_spike_emitter.sv
// tb/tb_spike_emitter.sv - directed scoreboard bench for spike_emitter (default and MAX_SPIKES=2 instances)
module tb_spike_emitter;

`ifdef SPIKE_EMITTER_GAP_EN
    localparam int G = 2;
`else
    localparam int G = 0;
`endif

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b1;
    logic [3:0] si [0:4];
    logic       sort_done  = 1'b0;
    logic       sort_done2 = 1'b0;
    logic       abort      = 1'b0;
    logic       ready      = 1'b0;

    logic       ev_valid, ev_last, busy, frame_done, overrun;
    logic [3:0] ev_addr, ev_rank;
    logic       d2_valid, d2_last, d2_busy, d2_done, d2_overrun;
    logic [3:0] d2_addr, d2_rank;

    typedef struct packed {
        logic [3:0] addr;
        logic [3:0] rank;
        logic       last;
    } ev_t;

    ev_t sb [$];
    int  n_checks = 0;
    int  n_pass   = 0;

    spike_emitter u_dut (
        .CLK(CLK), .RST_N(RST_N), .sorted_indexes(si), .sort_done(sort_done),
        .abort(abort), .event_ready(ready), .event_valid(ev_valid),
        .event_addr(ev_addr), .event_rank(ev_rank), .event_last(ev_last),
        .busy(busy), .frame_done(frame_done), .frame_overrun(overrun)
    );

    spike_emitter #(.MAX_SPIKES(2)) u_dut2 (
        .CLK(CLK), .RST_N(RST_N), .sorted_indexes(si), .sort_done(sort_done2),
        .abort(abort), .event_ready(ready), .event_valid(d2_valid),
        .event_addr(d2_addr), .event_rank(d2_rank), .event_last(d2_last),
        .busy(d2_busy), .frame_done(d2_done), .frame_overrun(d2_overrun)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic push_frame(input int max);
        for (int r = 0; r < max; r++) begin
            ev_t e;
            e.addr = si[r];
            e.rank = 4'(r);
            e.last = (r == max - 1);
            sb.push_back(e);
        end
    endtask

    // Called at the negedge with inputs already set for the coming posedge.
    task automatic cycle();
        if (ev_valid && ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_event", 1, 0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("sb_addr", ev_addr, e.addr);
                check("sb_rank", ev_rank, e.rank);
                check("sb_last", ev_last, e.last);
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (frame_done) seen = 1;
            else cycle();
        end
        check(tag, seen, 1);
        cycle();
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        si = '{4'd3, 4'd0, 4'd4, 4'd1, 4'd2};
        #1 RST_N = 1'b0;
        @(negedge CLK);
        check("rst_valid", ev_valid, 0);
        check("rst_addr", ev_addr, 0);
        check("rst_rank", ev_rank, 0);
        check("rst_last", ev_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_d2_valid", d2_valid, 0);
        RST_N = 1'b1;
        cycle();

        // back-to-back frame (or gapped when the feature is built)
        ready = 1'b1;
        sort_done = 1'b1;
        push_frame(5);
        cycle();
        sort_done = 1'b0;
        for (int c = 1; c <= 1 + 4 * (G + 1); c++) begin
            check("t1_valid", ev_valid, ((c - 1) % (G + 1)) == 0);
            check("t1_done_low", frame_done, 0);
            if (c == 1 + 4 * (G + 1)) check("t1_last", ev_last, 1);
            cycle();
        end
        check("t1_frame_done", frame_done, 1);
        check("t1_busy_finish", busy, 1);
        cycle();
        check("t1_idle_busy", busy, 0);
        check("t1_idle_done", frame_done, 0);
        check("t1_sb_empty", sb.size(), 0);

        // backpressure holds the first event
        ready = 1'b0;
        sort_done = 1'b1;
        push_frame(5);
        cycle();
        sort_done = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) ready = 1'b1;
            check("t2_hold_valid", ev_valid, 1);
            check("t2_hold_addr", ev_addr, 3);
            check("t2_hold_rank", ev_rank, 0);
            cycle();
        end
        check("t2_c5_valid", ev_valid, G == 0);
        check("t2_c5_rank", ev_rank, (G == 0) ? 1 : 0);
        wait_done("t2_done_seen");

        // MAX_SPIKES=2 instance
        sort_done2 = 1'b1;
        cycle();
        sort_done2 = 1'b0;
        check("t3_r0_valid", d2_valid, 1);
        check("t3_r0_addr", d2_addr, 3);
        check("t3_r0_rank", d2_rank, 0);
        check("t3_r0_last", d2_last, 0);
        for (int c = 0; c < G; c++) cycle();
        cycle();
        check("t3_r1_valid", d2_valid, 1);
        check("t3_r1_addr", d2_addr, 0);
        check("t3_r1_rank", d2_rank, 1);
        check("t3_r1_last", d2_last, 1);
        cycle();
        check("t3_frame_done", d2_done, 1);
        check("t3_no_event", d2_valid, 0);
        cycle();
        check("t3_idle", d2_busy, 0);

        // abort mid-frame
        sort_done = 1'b1;
        push_frame(5);
        cycle();
        sort_done = 1'b0;
        cycle();
        cycle();
        abort = 1'b1;
        check("t4_c3_valid", ev_valid, G == 0);
        cycle();
        abort = 1'b0;
        sb.delete();
        check("t4_valid_off", ev_valid, 0);
        check("t4_busy_off", busy, 0);
        for (int c = 0; c < 8; c++) begin
            check("t4_no_done", frame_done, 0);
            cycle();
        end
        sort_done = 1'b1;
        push_frame(5);
        cycle();
        sort_done = 1'b0;
        check("t4_restart_valid", ev_valid, 1);
        check("t4_restart_rank", ev_rank, 0);
        check("t4_restart_addr", ev_addr, 3);
        wait_done("t4_done_seen");

        // overrun: second sort_done ignored for data
        sort_done = 1'b1;
        push_frame(5);
        cycle();
        sort_done = 1'b0;
        check("t5_overrun_clear", overrun, 0);
        cycle();
        si = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        sort_done = 1'b1;
        cycle();
        sort_done = 1'b0;
        si = '{4'd3, 4'd0, 4'd4, 4'd1, 4'd2};
        check("t5_overrun_set", overrun, 1);
        wait_done("t5_done_seen");
        check("t5_overrun_sticky", overrun, 1);

        // abort and sort_done together in IDLE
        abort = 1'b1;
        sort_done = 1'b1;
        cycle();
        abort = 1'b0;
        sort_done = 1'b0;
        check("t6_not_started", busy, 0);
        check("t6_no_valid", ev_valid, 0);
        check("t6_overrun_kept", overrun, 1);

        // reset mid-frame
        sort_done = 1'b1;
        push_frame(5);
        cycle();
        sort_done = 1'b0;
        check("t7_overrun_cleared", overrun, 0);
        check("t7_valid", ev_valid, 1);
        cycle();
        sort_done = 1'b1;
        cycle();
        sort_done = 1'b0;
        check("t7_overrun_set", overrun, 1);
        check("t7_busy", busy, 1);
        RST_N = 1'b0;
        #1;
        check("t7_rst_valid", ev_valid, 0);
        check("t7_rst_addr", ev_addr, 0);
        check("t7_rst_rank", ev_rank, 0);
        check("t7_rst_last", ev_last, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_done", frame_done, 0);
        check("t7_rst_overrun", overrun, 0);
        sb.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check("t7_no_done", frame_done, 0);
            check("t7_stay_idle", busy, 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
